// File: rtl/pwm_cmd_pkg.sv
// Shared opcodes, FSM encodings and command bundle for pwm_cmd_ctrl.
// Used by the top and the per-channel register slice.
package pwm_cmd_pkg;

  localparam logic [3:0] OP_SET_TIMING  = 4'h1;
  localparam logic [3:0] OP_SET_PATTERN = 4'h2;
  localparam logic [3:0] OP_START       = 4'h3;
  localparam logic [3:0] OP_STOP        = 4'h4;
  localparam logic [3:0] OP_STOP_ALL    = 4'h5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  ch;
    logic [15:0] b;
    logic [15:0] c;
    logic [7:0]  d;
  } cmd_t;

  function automatic logic is_ch_op(input logic [3:0] op);
    return (op >= OP_SET_TIMING) && (op <= OP_STOP);
  endfunction

endpackage

// File: rtl/pwm_ch_regs.sv
// One channel: shadow/active timing+pattern registers, enable, done.
// Ports: strobes from decoder, operands, pwm_valid in; active values out.
module pwm_ch_regs
  import pwm_cmd_pkg::*;
#(
  parameter int PAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_timing,
  input  logic             set_pattern,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       duty_in,
  input  logic [15:0]      dessert_in,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [7:0]       pnum_in,
  input  logic             pwm_valid,
  output logic             pwm_en,
  output logic [7:0]       duty,
  output logic [7:0]       pulse_num,
  output logic [15:0]      dessert,
  output logic [PAT_W-1:0] pat,
  output logic             ch_done
);

  logic [7:0]       sh_duty;
  logic [7:0]       sh_pnum;
  logic [15:0]      sh_dessert;
  logic [PAT_W-1:0] sh_pat;
  logic             fin;

  // pulse_num of zero means run forever
  assign fin = pwm_en && pwm_valid && (pulse_num != 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_duty    <= 8'd1;
      sh_pnum    <= 8'd0;
      sh_dessert <= 16'd1;
      sh_pat     <= PAT_W'(1);
      duty       <= 8'd1;
      pulse_num  <= 8'd0;
      dessert    <= 16'd1;
      pat        <= PAT_W'(1);
      pwm_en     <= 1'b0;
      ch_done    <= 1'b0;
    end else begin
      ch_done <= fin;
      if (set_timing) begin
        sh_duty    <= duty_in;
        sh_dessert <= dessert_in;
      end
      if (set_pattern) begin
        sh_pat  <= pat_in;
        sh_pnum <= pnum_in;
      end
      if (start) begin
        duty      <= sh_duty;
        pulse_num <= sh_pnum;
        dessert   <= sh_dessert;
        pat       <= sh_pat;
        pwm_en    <= 1'b1;
      end
      if (stop || fin) begin
        pwm_en <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_cmd_ctrl.sv
// Packet command decoder driving NUM_CH pattern_pwm channels.
// Ports: recv_done/dataA..D packet in, pwm_busy/valid in; per-channel values + status out.
module pwm_cmd_ctrl
  import pwm_cmd_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int _PAT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         recv_done,
  input  logic [7:0]                   dataA,
  input  logic [15:0]                  dataB,
  input  logic [15:0]                  dataC,
  input  logic [7:0]                   dataD,
  input  logic [NUM_CH-1:0]            pwm_busy,
  input  logic [NUM_CH-1:0]            pwm_valid,
  output logic [NUM_CH-1:0]            pwm_en,
  output logic [NUM_CH*8-1:0]          duty_num,
  output logic [NUM_CH*8-1:0]          pulse_num,
  output logic [NUM_CH*16-1:0]         pulse_dessert,
  output logic [NUM_CH*_PAT_WIDTH-1:0] PAT,
  output logic                         cmd_ack,
  output logic                         cmd_err,
  output logic                         cmd_drop,
  output logic [NUM_CH-1:0]            ch_done
);

  logic [1:0]        state;
  cmd_t              cmd_q;
  logic [NUM_CH-1:0] hit;
  logic              ch_ok;
  logic              tgt_busy;
  logic              cmd_ok;
  logic              do_exec;
  logic [NUM_CH-1:0] st_timing;
  logic [NUM_CH-1:0] st_pattern;
  logic [NUM_CH-1:0] st_start;
  logic [NUM_CH-1:0] st_stop;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_hit
    assign hit[i] = (cmd_q.ch == 4'(i));
  end

  assign ch_ok    = |hit;
  // a channel still draining its burst keeps its active values locked
  assign tgt_busy = |(hit & (pwm_en | pwm_busy));

  always_comb begin
    cmd_ok = 1'b0;
    unique case (cmd_q.op)
      OP_SET_TIMING,
      OP_SET_PATTERN,
      OP_STOP:     cmd_ok = ch_ok;
      OP_START:    cmd_ok = ch_ok && !tgt_busy;
      OP_STOP_ALL: cmd_ok = 1'b1;
      default:     cmd_ok = 1'b0;
    endcase
  end

  assign do_exec = (state == ST_DECODE) && cmd_ok;

  assign st_timing  = {NUM_CH{do_exec && cmd_q.op == OP_SET_TIMING}} & hit;
  assign st_pattern = {NUM_CH{do_exec && cmd_q.op == OP_SET_PATTERN}} & hit;
  assign st_start   = {NUM_CH{do_exec && cmd_q.op == OP_START}} & hit;
  assign st_stop    = ({NUM_CH{do_exec && cmd_q.op == OP_STOP}} & hit)
                    | {NUM_CH{do_exec && cmd_q.op == OP_STOP_ALL}};

  assign cmd_drop = recv_done && (state != ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cmd_q   <= '0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (recv_done) begin
            cmd_q <= '{op: dataA[7:4], ch: dataA[3:0],
                       b: dataB, c: dataC, d: dataD};
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cmd_ack <= cmd_ok;
          cmd_err <= !cmd_ok;
          state   <= ST_EXEC;
        end
        ST_EXEC: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_ch_regs #(
      .PAT_W(_PAT_WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .set_timing (st_timing[i]),
      .set_pattern(st_pattern[i]),
      .start      (st_start[i]),
      .stop       (st_stop[i]),
      .duty_in    (cmd_q.d),
      .dessert_in (cmd_q.b),
      .pat_in     (cmd_q.c[_PAT_WIDTH-1:0]),
      .pnum_in    (cmd_q.d),
      .pwm_valid  (pwm_valid[i]),
      .pwm_en     (pwm_en[i]),
      .duty       (duty_num[i*8 +: 8]),
      .pulse_num  (pulse_num[i*8 +: 8]),
      .dessert    (pulse_dessert[i*16 +: 16]),
      .pat        (PAT[i*_PAT_WIDTH +: _PAT_WIDTH]),
      .ch_done    (ch_done[i])
    );
  end

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
// Bench for pwm_cmd_ctrl: directed packets, command-level model, per-cycle compare.
// Model tracks shadow/active values per channel and a 2-cycle command pipeline.
module tb_pwm_cmd_ctrl;

  localparam int NC = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          recv_done = 1'b0;
  logic [7:0]    dataA = '0;
  logic [15:0]   dataB = '0;
  logic [15:0]   dataC = '0;
  logic [7:0]    dataD = '0;
  logic [NC-1:0] pwm_busy = '0;
  logic [NC-1:0] pwm_valid = '0;
  logic [NC-1:0] pwm_en;
  logic [NC*8-1:0]  duty_num;
  logic [NC*8-1:0]  pulse_num;
  logic [NC*16-1:0] pulse_dessert;
  logic [NC*PW-1:0] PAT;
  logic          cmd_ack;
  logic          cmd_err;
  logic          cmd_drop;
  logic [NC-1:0] ch_done;

  pwm_cmd_ctrl #(.NUM_CH(NC), ._PAT_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .recv_done(recv_done),
    .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataD(dataD),
    .pwm_busy(pwm_busy), .pwm_valid(pwm_valid), .pwm_en(pwm_en),
    .duty_num(duty_num), .pulse_num(pulse_num),
    .pulse_dessert(pulse_dessert), .PAT(PAT),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .cmd_drop(cmd_drop),
    .ch_done(ch_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0]  sd [NC], sp [NC], ad [NC], ap [NC];
  logic [15:0] sg [NC], ag [NC], sx [NC], ax [NC];
  logic [NC-1:0] m_en, m_done;
  logic m_ack, m_err;
  int   cnt;
  logic [3:0]  p_op, p_ch;
  logic [15:0] p_b, p_c;
  logic [7:0]  p_d;

  task automatic m_apply();
    bit okch;
    okch = (p_ch < NC);
    case (p_op)
      4'h1: if (okch) begin sd[p_ch] = p_d; sg[p_ch] = p_b; m_ack = 1; end
            else m_err = 1;
      4'h2: if (okch) begin sx[p_ch] = p_c; sp[p_ch] = p_d; m_ack = 1; end
            else m_err = 1;
      4'h3: if (okch && !m_en[p_ch] && !pwm_busy[p_ch]) begin
              ad[p_ch] = sd[p_ch]; ag[p_ch] = sg[p_ch];
              ax[p_ch] = sx[p_ch]; ap[p_ch] = sp[p_ch];
              m_en[p_ch] = 1'b1; m_ack = 1;
            end else m_err = 1;
      4'h4: if (okch) begin m_en[p_ch] = 1'b0; m_ack = 1; end
            else m_err = 1;
      4'h5: begin m_en = '0; m_ack = 1; end
      default: m_err = 1;
    endcase
  endtask

  always @(posedge clk) begin
    logic [NC-1:0] nd;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        sd[i] = 1; sg[i] = 1; sp[i] = 0; sx[i] = 1;
        ad[i] = 1; ag[i] = 1; ap[i] = 0; ax[i] = 1;
      end
      m_en = '0; m_done = '0; m_ack = 0; m_err = 0; cnt = 0;
    end else begin
      nd = '0;
      for (int i = 0; i < NC; i++)
        if (m_en[i] && pwm_valid[i] && ap[i] != 0) nd[i] = 1'b1;
      m_ack = 0;
      m_err = 0;
      if (cnt == 2) m_apply();
      m_en = m_en & ~nd;
      m_done = nd;
      if (cnt > 0) cnt--;
      else if (recv_done) begin
        p_op = dataA[7:4]; p_ch = dataA[3:0];
        p_b = dataB; p_c = dataC; p_d = dataD;
        cnt = 2;
      end
    end
  end

  always @(negedge clk) begin
    logic [NC*8-1:0]  e_d, e_p;
    logic [NC*16-1:0] e_g, e_x;
    if (chk_on) begin
      for (int i = 0; i < NC; i++) begin
        e_d[i*8 +: 8] = ad[i];
        e_p[i*8 +: 8] = ap[i];
        e_g[i*16 +: 16] = ag[i];
        e_x[i*16 +: 16] = ax[i];
      end
      chk("m_pwm_en", pwm_en, m_en);
      chk("m_duty", duty_num, e_d);
      chk("m_pnum", pulse_num, e_p);
      chk("m_dessert", pulse_dessert, e_g);
      chk("m_pat", PAT, e_x);
      chk("m_ack", cmd_ack, m_ack);
      chk("m_err", cmd_err, m_err);
      chk("m_drop", cmd_drop, recv_done && cnt != 0 && !rst);
      chk("m_done", ch_done, m_done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [7:0] d);
    dataA = a; dataB = b; dataC = c; dataD = d;
    recv_done = 1'b1;
    tick();
    recv_done = 1'b0;
  endtask

  // packet, then sample the EXEC cycle
  task automatic cmd_at_exec(input logic [7:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [7:0] d);
    send(a, b, c, d);
    tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk_on = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_en", pwm_en, 2'b00);
    chk("rst_duty", duty_num, 16'h0101);
    chk("rst_dessert", pulse_dessert, 32'h0001_0001);
    chk("rst_pnum", pulse_num, 16'h0000);
    chk("rst_pat", PAT, 32'h0001_0001);
    chk("rst_pulses", {cmd_ack, cmd_err, cmd_drop, ch_done}, 5'b0);
    tick();

    cmd_at_exec(8'h11, 16'd90, 16'h0, 8'd10);
    chk("timing_ack", cmd_ack, 1'b1);
    chk("timing_no_active", duty_num, 16'h0101);
    tick();
    cmd_at_exec(8'h21, 16'h0, 16'h00F0, 8'd2);
    tick();
    cmd_at_exec(8'h31, 16'h0, 16'h0, 8'h0);
    chk("start1_ack", cmd_ack, 1'b1);
    chk("start1_duty", duty_num[15:8], 8'd10);
    chk("start1_dessert", pulse_dessert[31:16], 16'd90);
    chk("start1_pat", PAT[31:16], 16'h00F0);
    chk("start1_pnum", pulse_num[15:8], 8'd2);
    chk("start1_en", pwm_en, 2'b10);
    tick();
    pwm_valid = 2'b10;
    tick();
    pwm_valid = 2'b00;
    @(negedge clk);
    chk("valid1_en", pwm_en[1], 1'b0);
    chk("valid1_done", ch_done, 2'b10);
    tick();

    cmd_at_exec(8'h30, 16'h0, 16'h0, 8'h0);
    chk("start0_en", pwm_en, 2'b01);
    tick();
    pwm_valid = 2'b01;
    tick();
    pwm_valid = 2'b00;
    @(negedge clk);
    chk("inf_en", pwm_en, 2'b01);
    chk("inf_done", ch_done, 2'b00);
    tick();
    cmd_at_exec(8'h40, 16'h0, 16'h0, 8'h0);
    chk("stop0_ack", cmd_ack, 1'b1);
    chk("stop0_en", pwm_en, 2'b00);
    tick();

    cmd_at_exec(8'h32, 16'h0, 16'h0, 8'h0);
    chk("badch_err", {cmd_err, cmd_ack}, 2'b10);
    tick();
    cmd_at_exec(8'h90, 16'h0, 16'h0, 8'h0);
    chk("badop_err", {cmd_err, cmd_ack}, 2'b10);
    tick();
    pwm_busy = 2'b01;
    cmd_at_exec(8'h30, 16'h0, 16'h0, 8'h0);
    chk("busy_err", cmd_err, 1'b1);
    pwm_busy = 2'b00;
    tick();

    dataA = 8'h11; dataB = 16'd7; dataD = 8'd3;
    recv_done = 1'b1;
    tick();
    dataA = 8'h21; dataC = 16'h5555;
    @(negedge clk);
    chk("drop_pulse", cmd_drop, 1'b1);
    tick();
    recv_done = 1'b0;
    @(negedge clk);
    chk("drop_first_ack", cmd_ack, 1'b1);
    tick();

    cmd_at_exec(8'h30, 16'h0, 16'h0, 8'h0);
    chk("restart0_duty", duty_num[7:0], 8'd1);
    tick();
    cmd_at_exec(8'h30, 16'h0, 16'h0, 8'h0);
    chk("rerun_err", cmd_err, 1'b1);
    tick();
    cmd_at_exec(8'h31, 16'h0, 16'h0, 8'h0);
    chk("run_both", pwm_en, 2'b11);
    tick();
    cmd_at_exec(8'h5F, 16'h0, 16'h0, 8'h0);
    chk("stopall", {cmd_ack, pwm_en}, 3'b100);
    tick();

    cmd_at_exec(8'h31, 16'h0, 16'h0, 8'h0);
    tick();
    send(8'h41, 16'h0, 16'h0, 8'h0);
    pwm_valid = 2'b10;
    tick();
    pwm_valid = 2'b00;
    @(negedge clk);
    chk("stopvalid", {cmd_ack, pwm_en, ch_done}, 5'b1_00_10);
    tick();

    send(8'h11, 16'd44, 16'h0, 8'd55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", cmd_ack, 1'b0);
    chk("rstmid_vals", {duty_num, pulse_dessert}, 48'h0101_0001_0001);
    tick();
    cmd_at_exec(8'h30, 16'h0, 16'h0, 8'h0);
    chk("rstmid_shadow", duty_num, 16'h0101);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
